// File: rtl/package_settings.sv
// Shared settings for the trapezoidal shaper.
// Holds default widths, the default delay-line depth and K/L values
// applied at reset, and the state type used by the peak detector.
package package_settings;

    localparam int unsigned SIZE_ADC_DATA     = 14;
    localparam int unsigned SIZE_FILTER_DATA  = 16;
    localparam int unsigned DEFAULT_MAX_DEPTH = 64;
    localparam int unsigned DEFAULT_K         = 4;
    localparam int unsigned DEFAULT_L         = 2;

    typedef enum logic [1:0] {
        PK_IDLE  = 2'd0,
        PK_TRACK = 2'd1,
        PK_EMIT  = 2'd2
    } peak_state_e;

endpackage

// File: rtl/trap_delay_line.sv
// Circular sample buffer for the trapezoidal shaper.
// One sample is written per clk at the write pointer, which wraps
// DEPTH-1 -> 0. Three taps are read combinationally at programmable
// delays behind the sample currently being written.
//   clk, reset          : clock, async active-high reset (pointer only)
//   wr_data             : sample written on this edge
//   dly_a/dly_b/dly_c   : tap delays in samples (1..DEPTH-1)
//   tap_a/tap_b/tap_c   : samples written dly_* edges ago
module trap_delay_line #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] dly_a,
    input  logic [$clog2(DEPTH)-1:0] dly_b,
    input  logic [$clog2(DEPTH)-1:0] dly_c,
    output logic [DATA_W-1:0]        tap_a,
    output logic [DATA_W-1:0]        tap_b,
    output logic [DATA_W-1:0]        tap_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    // Contents are never reset; stale entries are masked by the fill counter upstream.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     wr_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        tap_a    = mem[wr_ptr_q - dly_a];
        tap_b    = mem[wr_ptr_q - dly_b];
        tap_c    = mem[wr_ptr_q - dly_c];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/trap_shaper.sv
// Trapezoidal pulse shaper with peak detection.
// d[n] = x[n] - x[n-K] - x[n-K-L] + x[n-2K-L] is accumulated and
// saturated to OUT_W; a sample on edge n reaches output_data after n+2.
//   clk, reset        : clock, async active-high reset
//   input_data        : unsigned ADC sample, one per clk
//   param_k/param_l   : requested rise / flat-top lengths
//   param_load        : strobe requesting a K/L update
//   threshold         : signed peak-detect threshold
//   output_data       : signed shaped sample
//   peak_data         : maximum of the last detected pulse (held)
//   peak_valid        : one-cycle strobe qualifying peak_data
//   param_err         : one-cycle strobe for a rejected load
//   overflow          : sticky saturation flag
module trap_shaper
    import package_settings::*;
#(
    parameter int unsigned DATA_W    = SIZE_ADC_DATA,
    parameter int unsigned OUT_W     = SIZE_FILTER_DATA,
    parameter int unsigned MAX_DEPTH = DEFAULT_MAX_DEPTH,
    parameter int unsigned DEF_K     = DEFAULT_K,
    parameter int unsigned DEF_L     = DEFAULT_L
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            input_data,
    input  logic [$clog2(MAX_DEPTH)-1:0] param_k,
    input  logic [$clog2(MAX_DEPTH)-1:0] param_l,
    input  logic                         param_load,
    input  logic signed [OUT_W-1:0]      threshold,
    output logic signed [OUT_W-1:0]      output_data,
    output logic signed [OUT_W-1:0]      peak_data,
    output logic                         peak_valid,
    output logic                         param_err,
    output logic                         overflow
);
    localparam int unsigned AW    = $clog2(MAX_DEPTH);
    localparam int unsigned D_W   = DATA_W + 2;
    localparam int unsigned ACC_W = DATA_W + AW + 2;

    localparam logic [AW+1:0]            SPAN_LIMIT = (AW+2)'(MAX_DEPTH - 1);
    localparam logic signed [ACC_W-1:0]  OUT_MAX    = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  OUT_MIN    = ACC_W'(-(2 ** (OUT_W - 1)));

    // Parameter registers and load qualification
    logic [AW-1:0] k_q, k_d, l_q, l_d;
    logic [AW+1:0] span_req;
    logic          load_ok;
    logic          param_err_q, param_err_d;

    // Datapath
    logic [AW-1:0]            dly_a, dly_b, dly_c;
    logic [DATA_W-1:0]        tap_a, tap_b, tap_c;
    logic [AW-1:0]            fill_q, fill_d, fill_eff;
    logic signed [D_W-1:0]    x_s, a_s, b_s, c_s;
    logic signed [D_W-1:0]    d_q, d_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  out_q, out_d;
    logic                     sat;
    logic                     overflow_q, overflow_d;

    // Peak detector
    peak_state_e              state_q, state_d;
    logic signed [OUT_W-1:0]  max_q, max_d;
    logic signed [OUT_W-1:0]  peak_q, peak_d;
    logic                     pv_q, pv_d;

    always_comb begin
        span_req    = {1'b0, param_k, 1'b0} + {2'b00, param_l};
        load_ok     = param_load && (param_k != '0) && (span_req <= SPAN_LIMIT);
        param_err_d = param_load && !load_ok;
        k_d         = k_q;
        l_d         = l_q;
        if (load_ok) begin
            k_d = param_k;
            l_d = param_l;
        end
        // Accepted K/L keep 2K+L below MAX_DEPTH, so AW-bit sums never wrap.
        dly_a = k_q;
        dly_b = k_q + l_q;
        dly_c = k_q + k_q + l_q;
    end

    trap_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_DEPTH)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .wr_data (input_data),
        .dly_a   (dly_a),
        .dly_b   (dly_b),
        .dly_c   (dly_c),
        .tap_a   (tap_a),
        .tap_b   (tap_b),
        .tap_c   (tap_c)
    );

    always_comb begin
        // The sample on a load edge is the first one after the clear,
        // so every tap is masked for it regardless of old or new K/L.
        fill_eff = load_ok ? '0 : fill_q;
        x_s      = $signed({2'b00, input_data});
        a_s      = (fill_eff >= dly_a) ? $signed({2'b00, tap_a}) : '0;
        b_s      = (fill_eff >= dly_b) ? $signed({2'b00, tap_b}) : '0;
        c_s      = (fill_eff >= dly_c) ? $signed({2'b00, tap_c}) : '0;
        d_d      = x_s - a_s - b_s + c_s;

        if (load_ok) begin
            fill_d = AW'(1);
        end else if (fill_q >= dly_c) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + AW'(1);
        end

        if (load_ok) begin
            acc_d = '0;
        end else begin
            acc_d = acc_q + {{(ACC_W-D_W){d_q[D_W-1]}}, d_q};
        end

        sat   = 1'b0;
        out_d = OUT_W'(acc_q);
        if (load_ok) begin
            out_d = '0;
        end else if (acc_q > OUT_MAX) begin
            out_d = OUT_W'(OUT_MAX);
            sat   = 1'b1;
        end else if (acc_q < OUT_MIN) begin
            out_d = OUT_W'(OUT_MIN);
            sat   = 1'b1;
        end
        overflow_d = overflow_q | sat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q         <= AW'(DEF_K);
            l_q         <= AW'(DEF_L);
            param_err_q <= 1'b0;
            fill_q      <= '0;
            d_q         <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            k_q         <= k_d;
            l_q         <= l_d;
            param_err_q <= param_err_d;
            fill_q      <= fill_d;
            d_q         <= d_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Peak detector: peak_valid is high for exactly the cycle spent in EMIT.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        peak_d  = peak_q;
        pv_d    = 1'b0;
        case (state_q)
            PK_IDLE: begin
                if (out_q > threshold) begin
                    state_d = PK_TRACK;
                    max_d   = out_q;
                end
            end
            PK_TRACK: begin
                if (out_q > max_q) begin
                    max_d = out_q;
                end
                if (out_q <= threshold) begin
                    state_d = PK_EMIT;
                    peak_d  = max_q;
                    pv_d    = 1'b1;
                end
            end
            PK_EMIT: begin
                state_d = PK_IDLE;
            end
            default: begin
                state_d = PK_IDLE;
            end
        endcase
        if (load_ok) begin
            state_d = PK_IDLE;
            max_d   = max_q;
            peak_d  = peak_q;
            pv_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PK_IDLE;
            max_q   <= '0;
            peak_q  <= '0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            peak_q  <= peak_d;
            pv_q    <= pv_d;
        end
    end

    assign output_data = out_q;
    assign peak_data   = peak_q;
    assign peak_valid  = pv_q;
    assign param_err   = param_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_trap_shaper.sv
module tb_trap_shaper;

    localparam int unsigned DATA_W    = 14;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned MAX_DEPTH = 64;
    localparam int unsigned AW        = 6;
    localparam int          K_RESET   = 4;
    localparam int          L_RESET   = 2;
    localparam longint      OMAX      = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint      OMIN      = -(longint'(1) << (OUT_W - 1));

    logic                    clk = 1'b0;
    logic                    reset;
    logic [DATA_W-1:0]       input_data;
    logic [AW-1:0]           param_k;
    logic [AW-1:0]           param_l;
    logic                    param_load;
    logic signed [OUT_W-1:0] threshold;
    logic signed [OUT_W-1:0] output_data;
    logic signed [OUT_W-1:0] peak_data;
    logic                    peak_valid;
    logic                    param_err;
    logic                    overflow;

    trap_shaper #(
        .DATA_W    (DATA_W),
        .OUT_W     (OUT_W),
        .MAX_DEPTH (MAX_DEPTH),
        .DEF_K     (K_RESET),
        .DEF_L     (L_RESET)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .param_k     (param_k),
        .param_l     (param_l),
        .param_load  (param_load),
        .threshold   (threshold),
        .output_data (output_data),
        .peak_data   (peak_data),
        .peak_valid  (peak_valid),
        .param_err   (param_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        longint out;
        bit     pv;
        longint peak;
        bit     err;
        bit     ovf;
    } exp_t;

    typedef struct {
        longint v;
        bit     clamped;
    } lat_t;

    exp_t   sb_q[$];
    longint hist[$];   // samples since last reset/accepted load, newest last
    lat_t   lat[$];    // shaped values waiting to appear on output_data
    longint run_sum;
    int     m_k, m_l;
    longint m_out, m_peak, m_max;
    bit     m_pv, m_err, m_ovf, m_inpulse;

    function automatic void lat_prime();
        lat_t z;
        z.v = 0;
        z.clamped = 1'b0;
        lat.delete();
        lat.push_back(z);
        lat.push_back(z);
    endfunction

    function automatic void model_reset();
        hist.delete();
        lat_prime();
        run_sum   = 0;
        m_k       = K_RESET;
        m_l       = L_RESET;
        m_out     = 0;
        m_peak    = 0;
        m_max     = 0;
        m_pv      = 1'b0;
        m_err     = 1'b0;
        m_ovf     = 1'b0;
        m_inpulse = 1'b0;
    endfunction

    function automatic longint tap(input int i);
        if (i < hist.size()) return hist[hist.size() - 1 - i];
        return 0;
    endfunction

    function automatic void model_edge(input longint x, input bit load, input int pk,
                                       input int pl, input longint thr);
        longint prev_out;
        bit     load_ok;
        lat_t   y;
        lat_t   e;
        prev_out = m_out;
        load_ok  = load && (pk >= 1) && (2 * pk + pl <= int'(MAX_DEPTH) - 1);
        m_err    = load && !load_ok;

        // pulse detection on the output stream seen before this edge
        if (load_ok) begin
            m_inpulse = 1'b0;
            m_pv      = 1'b0;
        end else if (m_pv) begin
            m_pv = 1'b0;
        end else if (!m_inpulse) begin
            if (prev_out > thr) begin
                m_inpulse = 1'b1;
                m_max     = prev_out;
            end
        end else begin
            if (prev_out > m_max) m_max = prev_out;
            if (prev_out <= thr) begin
                m_pv      = 1'b1;
                m_peak    = m_max;
                m_inpulse = 1'b0;
            end
        end

        // trapezoid
        if (load_ok) begin
            m_k = pk;
            m_l = pl;
            hist.delete();
            run_sum = 0;
            lat_prime();
        end
        hist.push_back(x);
        if (hist.size() > int'(MAX_DEPTH)) void'(hist.pop_front());
        run_sum += tap(0) - tap(m_k) - tap(m_k + m_l) + tap(2 * m_k + m_l);
        y.clamped = 1'b0;
        y.v       = run_sum;
        if (run_sum > OMAX) begin
            y.v = OMAX;
            y.clamped = 1'b1;
        end else if (run_sum < OMIN) begin
            y.v = OMIN;
            y.clamped = 1'b1;
        end
        lat.push_back(y);
        e     = lat.pop_front();
        m_out = e.v;
        m_ovf = m_ovf | e.clamped;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick(input logic [DATA_W-1:0] x, input bit load = 1'b0,
                        input int pk = 0, input int pl = 0);
        exp_t e;
        input_data = x;
        param_load = load;
        param_k    = AW'(pk);
        param_l    = AW'(pl);
        if (reset) model_reset();
        else model_edge(longint'(x), load, pk, pl, longint'(threshold));
        @(posedge clk);
        e.out  = m_out;
        e.pv   = m_pv;
        e.peak = m_peak;
        e.err  = m_err;
        e.ovf  = m_ovf;
        sb_q.push_back(e);
        #1;
        param_load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"},  longint'(output_data), 0);
        check({tag, "_peak"}, longint'(peak_data), 0);
        check({tag, "_pv"},   longint'(peak_valid), 0);
        check({tag, "_err"},  longint'(param_err), 0);
        check({tag, "_ovf"},  longint'(overflow), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (!reset) begin
                check("output_data", longint'(output_data), e.out);
                check("peak_valid",  longint'(peak_valid), longint'(e.pv));
                check("peak_data",   longint'(peak_data), e.peak);
                check("param_err",   longint'(param_err), longint'(e.err));
                check("overflow",    longint'(overflow), longint'(e.ovf));
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] x;
        int                t_rand;
        int                maxv;
        reset      = 1'b0;
        input_data = '0;
        param_load = 1'b0;
        param_k    = '0;
        param_l    = '0;
        threshold  = 16'sd250;
        model_reset();
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) tick('0);
        reset = 1'b0;

        // step 0 -> 100 with K=4, L=2, threshold 250
        repeat (12) tick('0);
        repeat (20) tick(14'd100);
        repeat (15) tick('0);

        // rejected load: 2*30+10 exceeds depth-1; K/L must stay 4/2
        tick('0, 1'b1, 30, 10);
        repeat (15) tick('0);
        repeat (20) tick(14'd100);
        repeat (15) tick('0);

        // accepted load K=8, L=0 during steady input 50
        repeat (30) tick(14'd50);
        tick(14'd50, 1'b1, 8, 0);
        repeat (25) tick(14'd50);

        // saturation with K=31, L=1
        tick('0, 1'b1, 31, 1);
        repeat (5) tick('0);
        repeat (70) tick(14'h3FFF);
        repeat (70) tick('0);

        // reset while tracking a pulse
        reset = 1'b1;
        model_reset();
        #1 check_reset_outputs("reset_pre");
        tick('0);
        reset = 1'b0;
        threshold = 16'sd250;
        repeat (10) tick('0);
        repeat (7) tick(14'd100);
        reset = 1'b1;
        model_reset();
        #1 check_reset_outputs("reset_mid");
        repeat (2) tick('0);
        reset = 1'b0;
        repeat (25) tick('0);

        // randomized traffic with occasional loads and threshold changes
        x    = '0;
        maxv = 100;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) begin
                t_rand    = int'($urandom_range(0, 20000)) - 2000;
                threshold = t_rand[OUT_W-1:0];
            end
            if (i % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: maxv = 100;
                    1: maxv = 1000;
                    2: maxv = 8000;
                    default: maxv = 16383;
                endcase
            end
            if ($urandom_range(0, 7) == 0) x = DATA_W'($urandom_range(0, maxv));
            if ($urandom_range(0, 39) == 0)
                tick(x, 1'b1, int'($urandom_range(0, 40)), int'($urandom_range(0, 20)));
            else
                tick(x);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", longint'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
